jtbubl_snd_comm: RTL
====================

# jtbubl_snd_comm

Main-CPU side of the main/sound communication channel. It drives the command latch and strobe seen by the sound CPU and captures the sound CPU's reply byte on its strobe. It also keeps a reply-pending flag, reports both handshake flags to the main CPU, and owns the sound CPU reset, including a pulse stretcher. It sits on the main CPU bus decode, between the main Z80 and the sound subsystem.

## Interface
Parameters:
- RST_LEN, default 16: minimum number of cen cycles that snd_rstn stays low after any reset source is released (1..255).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- cen  in  1  clock enable used only by the reset stretcher
- cs  in  1  register block select, decoded by the main CPU
- addr  in  2  register offset
- wr_n  in  1  main CPU write strobe, active low
- rd_n  in  1  main CPU read strobe, active low
- din  in  8  main CPU data out
- dout  out  8  register read data
- snd_latch  out  8  command byte to the sound CPU
- snd_stb  out  1  one-clk pulse per command write
- snd_flag  in  1  sound-side flag; low = command not yet read by the sound CPU
- main_latch  in  8  reply byte from the sound CPU
- main_stb  in  1  sound CPU reply write strobe, may be several clk wide
- main_flag  out  1  high = reply pending, not yet read by the main CPU
- snd_rstn  out  1  sound CPU reset, active low
- irq_n  out  1  main CPU interrupt, active low (see Configuration)

## Operation
- Write detect: wr_act = cs & ~wr_n. A write is accepted only on the rising edge of wr_act, i.e. the first clk it is seen high. It is accepted once per access, however long the access lasts.
- Read detect: rd_act = cs & ~rd_n. A read side effect fires only on the rising edge of rd_act.
- Offset 0 write: snd_latch <= din; snd_stb high for exactly one clk on the following clock.
- Offset 0 read: dout = reply register. The rising edge of rd_act clears main_flag.
- Offset 1 read: dout = {5'h1f, irq_en, main_flag, snd_flag}. Without the macro, bit 2 reads 1.
- Offset 2 write: hold <= din[0]. hold = 1 forces the sound CPU into reset.
- Offset 3 write: irq_en <= din[0]. Without the macro this write is ignored.
- Any other read returns 8'hff. dout is also 8'hff whenever cs is low.
- Reply capture: on the rising edge of main_stb, reply <= main_latch and main_flag <= 1.
  - If a capture and the clearing read edge fall on the same clk, set wins: main_flag = 1 and reply holds the new byte.
  - A new capture while main_flag is already 1 overwrites reply. There is no overrun error.
- Reset stretcher: counter cnt, 8 bits.
  - While hold = 1, cnt loads RST_LEN.
  - Otherwise cnt decrements on each cen while nonzero.
  - snd_rstn = (cnt == 0) & ~hold.
- irq_n = ~(irq_en & main_flag), registered.

## Timing
- Reset values (rstn low, asynchronous):
  - snd_latch = 0, snd_stb = 0, main_flag = 0, reply = 0, dout = 8'hff, irq_n = 1.
  - hold = 0, irq_en = 0, cnt = RST_LEN, so snd_rstn = 0.
- After rstn rises, snd_rstn goes high after RST_LEN cen pulses plus one clk.
- Register reads have one clk latency: dout is valid the clk after rd_act rises and holds while rd_act stays high.
- Command write: snd_latch changes and snd_stb goes high on the same clk edge, one clk after wr_act rises. snd_stb falls on the next edge.
- Back-to-back command writes with no idle clk between accesses are impossible, because wr_act must fall between them. Each access yields exactly one pulse.
- Capture: main_flag and reply update one clk after main_stb rises. main_stb and main_latch are already synchronous to clk.
- Writing hold = 1 while cnt is counting reloads cnt. Writing hold = 0 mid-count never shortens the stretch.
- hold and irq_en survive the sound CPU reset. Only rstn clears them.

## Configuration
- JTBUBL_SNDIRQ_EN defined:
  - Offset 3 controls irq_en.
  - irq_n asserts while main_flag = 1 and stays asserted until the offset-0 read clears main_flag.
- Not defined:
  - irq_en stays 0 and irq_n is tied to 1.
  - Offset 3 writes are ignored and status bit 2 reads 1.
  - No irq_en register is synthesized.

## Structure
- Shared package/header jtbubl_snd_pkg:
  - register offsets REG_CMD = 0, REG_STAT = 1, REG_RST = 2, REG_IRQ = 3;
  - status bit positions;
  - default RST_LEN.
- One sub-module, jtbubl_rst_stretch: contains the cnt, hold and cen logic and outputs snd_rstn. It is reusable for the Tokio variant.
- Edge detectors and registers stay in the top module.

## Test plan
- Reset: rstn low then high, RST_LEN = 16, cen every 4 clk -> snd_rstn low for 16 cen, then 1. All other outputs at their reset values.
- Command: write 8'h5a to offset 0, with wr_act held 6 clk -> snd_latch = 8'h5a and exactly one snd_stb pulse, 1 clk wide, 1 clk after the write start.
- Reply: main_latch = 8'h3c with a 3-clk main_stb -> main_flag = 1 and status = 8'hfb when snd_flag = 1. Read offset 0 -> dout = 8'h3c, then main_flag = 0.
- Collision: main_stb edge on the same clk as the offset-0 read edge, new byte 8'h77 -> main_flag stays 1 and the next read returns 8'h77.
- Reset hold: write offset 2 = 1 mid-stretch, then write 0 -> snd_rstn stays low until RST_LEN full cen after the release.
- IRQ (macro on): write offset 3 = 1, then reply strobe -> irq_n = 0 one clk after main_flag rises, and back to 1 after the offset-0 read. With the macro off, irq_n is constant 1.

Source files
------------

// File: rtl/jtbubl_snd_pkg.sv
// Shared definitions for the Bubble Bobble main/sound communication block:
// register offsets, status bit positions and the default reset stretch.
package jtbubl_snd_pkg;

   typedef enum logic [1:0] {
      REG_CMD  = 2'd0,
      REG_STAT = 2'd1,
      REG_RST  = 2'd2,
      REG_IRQ  = 2'd3
   } reg_e;

   localparam int STAT_SND  = 0;
   localparam int STAT_MAIN = 1;
   localparam int STAT_IRQ  = 2;

   localparam int RST_LEN_DEF = 16;

   // Status byte seen by the main CPU; unused upper bits read as 1
   function automatic logic [7:0] stat_byte(input logic irq, input logic main, input logic snd);
      logic [7:0] s;
      s            = 8'hff;
      s[STAT_IRQ]  = irq;
      s[STAT_MAIN] = main;
      s[STAT_SND]  = snd;
      return s;
   endfunction

endpackage

// File: rtl/jtbubl_snd_comm_if.sv
// Main CPU bus as seen by the sound communication registers.
interface jtbubl_snd_comm_if;
   logic       cs;
   logic [1:0] addr;
   logic       wr_n;
   logic       rd_n;
   logic [7:0] din;
   logic [7:0] dout;

   modport master (output cs, addr, wr_n, rd_n, din, input  dout);
   modport slave  (input  cs, addr, wr_n, rd_n, din, output dout);
endinterface

// File: rtl/jtbubl_rst_stretch.sv
// Sound CPU reset stretcher: a hold bit forces reset, and the release is
// delayed by RST_LEN cen pulses. Shared with the Tokio variant.
module jtbubl_rst_stretch
   import jtbubl_snd_pkg::*;
#(
   parameter int RST_LEN = RST_LEN_DEF
)(
   input  logic clk,
   input  logic rstn,
   input  logic cen,
   input  logic hold_we,
   input  logic hold_din,
   output logic hold,
   output logic snd_rstn
);

   localparam logic [7:0] LEN = 8'(RST_LEN);

   logic [7:0] cnt;

   // hold bit, only cleared by the system reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        hold <= 1'b0;
      else if (hold_we) hold <= hold_din;
   end

   // reload while held so a release always gets the full stretch
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                   cnt <= LEN;
      else if (hold)               cnt <= LEN;
      else if (cen && cnt != 8'd0) cnt <= cnt - 8'd1;
   end

   // registered output: release lands one clk after the count expires
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) snd_rstn <= 1'b0;
      else       snd_rstn <= (cnt == 8'd0) & ~hold;
   end

endmodule

// File: rtl/jtbubl_snd_comm.sv
// Main-CPU side of the main/sound channel: command latch and strobe,
// reply capture with pending flag, status register, sound CPU reset.
// Optional macro JTBUBL_SNDIRQ_EN adds the reply interrupt (offset 3).
module jtbubl_snd_comm
   import jtbubl_snd_pkg::*;
#(
   parameter int RST_LEN = RST_LEN_DEF
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             cen,
   jtbubl_snd_comm_if.slave bus,
   output logic [7:0]       snd_latch,
   output logic             snd_stb,
   input  logic             snd_flag,
   input  logic [7:0]       main_latch,
   input  logic             main_stb,
   output logic             main_flag,
   output logic             snd_rstn,
   output logic             irq_n
);

   logic       wr_act, rd_act, wr_l, rd_l, stb_l;
   logic       wr_edge, rd_edge, stb_edge;
   logic [7:0] reply, dout_r, rd_mux;
   logic       irq_en, stat_irq, hold;

   assign wr_act   = bus.cs & ~bus.wr_n;
   assign rd_act   = bus.cs & ~bus.rd_n;
   assign wr_edge  = wr_act & ~wr_l;
   assign rd_edge  = rd_act & ~rd_l;
   assign stb_edge = main_stb & ~stb_l;

   // previous-cycle copies for edge detection
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_l  <= 1'b0;
         rd_l  <= 1'b0;
         stb_l <= 1'b0;
      end else begin
         wr_l  <= wr_act;
         rd_l  <= rd_act;
         stb_l <= main_stb;
      end
   end

   // command latch with a single-clk strobe per access
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         snd_latch <= 8'd0;
         snd_stb   <= 1'b0;
      end else begin
         snd_stb <= 1'b0;
         if (wr_edge && bus.addr == REG_CMD) begin
            snd_latch <= bus.din;
            snd_stb   <= 1'b1;
         end
      end
   end

   // reply capture; a capture beats a same-cycle clearing read
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         reply     <= 8'd0;
         main_flag <= 1'b0;
      end else if (stb_edge) begin
         reply     <= main_latch;
         main_flag <= 1'b1;
      end else if (rd_edge && bus.addr == REG_CMD) begin
         main_flag <= 1'b0;
      end
   end

`ifdef JTBUBL_SNDIRQ_EN
   // interrupt enable, survives the sound CPU reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                 irq_en <= 1'b0;
      else if (wr_edge && bus.addr == REG_IRQ)   irq_en <= bus.din[0];
   end

   // interrupt follows the pending flag one clk later
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) irq_n <= 1'b1;
      else       irq_n <= ~(irq_en & main_flag);
   end

   assign stat_irq = irq_en;
`else
   assign irq_en   = 1'b0;
   assign irq_n    = 1'b1;
   assign stat_irq = 1'b1;
`endif

   // read data selection
   always_comb begin
      rd_mux = 8'hff;
      case (bus.addr)
         REG_CMD:  rd_mux = reply;
         REG_STAT: rd_mux = stat_byte(stat_irq, main_flag, snd_flag);
         default:  rd_mux = 8'hff;
      endcase
   end

   // read data register, valid one clk after the read starts
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) dout_r <= 8'hff;
      else       dout_r <= rd_act ? rd_mux : 8'hff;
   end

   assign bus.dout = bus.cs ? dout_r : 8'hff;

   jtbubl_rst_stretch #(.RST_LEN(RST_LEN)) u_rst (
      .clk      (clk),
      .rstn     (rstn),
      .cen      (cen),
      .hold_we  (wr_edge && bus.addr == REG_RST),
      .hold_din (bus.din[0]),
      .hold     (hold),
      .snd_rstn (snd_rstn)
   );

endmodule
